// File: rtl/spi_master_mcs.sv
// spi_master_mcs
//   Multi-configuration SPI master. Each transfer is set up by one valid/ready
//   handshake. The handshake latches the SCK mode (CPOL/CPHA), the bit order,
//   the word length, the SCK half-period divider, the chip-select index and the
//   transmit word. The block runs one transfer at a time, then pulses done and
//   presents the received word.
//
// Ports
//   clk, rst_n          system clock, asynchronous active-low reset
//   start_valid/ready   transfer request handshake (ready only while idle)
//   cfg_cpol, cfg_cpha  SCK idle level and sampling phase
//   cfg_lsb_first       1 = bit 0 is shifted first
//   cfg_len             word length minus one (1..W bits)
//   cfg_div             SCK half-period minus one, in clk cycles
//   cfg_cs_sel          slave index; out-of-range values assert no chip select
//   din                 transmit word, right-aligned
//   abort               cancels an active transfer (no done, dout kept)
//   done                one-cycle completion pulse
//   dout                received word, right-aligned, held until the next done
//   sck, cs_n, mosi     SPI outputs (all registered)
//   miso                SPI input
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | ready for a request, chip selects released, sck at latched CPOL
// SETUP | chip select asserted, D cycles before the first SCK edge
// SHIFT | 2N SCK edges, one every D cycles, sampling / driving per CPHA
// HOLD  | D cycles with chip select still asserted after the last edge
// DONE  | one cycle: done pulse, dout updated, chip selects released

module spi_master_mcs #(
  parameter int  WIDTH_LOG = 4,
  parameter int  CS_NUM    = 4,
  parameter int  DIV_WIDTH = 8,
  localparam int W         = 1 << WIDTH_LOG,
  localparam int CS_SEL_W  = (CS_NUM > 1) ? $clog2(CS_NUM) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic                 cfg_cpol,
  input  logic                 cfg_cpha,
  input  logic                 cfg_lsb_first,
  input  logic [WIDTH_LOG-1:0] cfg_len,
  input  logic [DIV_WIDTH-1:0] cfg_div,
  input  logic [CS_SEL_W-1:0]  cfg_cs_sel,
  input  logic [W-1:0]         din,
  input  logic                 abort,
  output logic                 done,
  output logic [W-1:0]         dout,
  output logic                 sck,
  output logic [CS_NUM-1:0]    cs_n,
  output logic                 mosi,
  input  logic                 miso
);

  // Edge counter must hold 2N with N up to W.
  localparam int EW = WIDTH_LOG + 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t               state_q, state_nxt;
  logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_nxt;
  logic [EW-1:0]        edges_q, edges_nxt;
  logic                 cpol_q, cpol_nxt;
  logic                 cpha_q, cpha_nxt;
  logic                 lsb_q, lsb_nxt;
  logic [WIDTH_LOG-1:0] len_q, len_nxt;
  logic [DIV_WIDTH-1:0] div_q, div_nxt;
  logic [CS_SEL_W-1:0]  cs_sel_q, cs_sel_nxt;
  logic [W-1:0]         tx_q, tx_nxt;
  logic [W-1:0]         rx_q, rx_nxt;

  logic                 sck_nxt;
  logic                 mosi_nxt;
  logic                 done_nxt;
  logic [W-1:0]         dout_nxt;
  logic [CS_NUM-1:0]    cs_n_nxt;
  logic                 start_ready_nxt;
  logic                 cs_active_nxt;

  logic                 accept;
  logic                 tc;
  logic                 lead;
  logic                 last_edge;
  logic                 sample_edge;
  logic                 drive_edge;
  logic [W-1:0]         tx_aligned;

  function automatic logic head_bit(input logic [W-1:0] v, input logic lsb);
    return lsb ? v[0] : v[W-1];
  endfunction

  function automatic logic [W-1:0] advance(input logic [W-1:0] v, input logic lsb);
    return lsb ? (v >> 1) : (v << 1);
  endfunction

  assign accept      = start_valid && start_ready;
  assign tc          = (div_cnt_q == '0);
  // The coming SCK edge is a leading edge whenever sck still sits at CPOL.
  assign lead        = (sck == cpol_q);
  assign last_edge   = (edges_q == EW'(1));
  assign sample_edge = lead ^ cpha_q;
  // CPHA=0 already put the first bit out during SETUP and must not shift
  // past the last bit on the final trailing edge.
  assign drive_edge  = cpha_q ? lead : (!lead && !last_edge);
  // MSB-first words are pre-shifted so bit N-1 sits in the top position.
  assign tx_aligned  = cfg_lsb_first ? din : (din << (~cfg_len));

  always_comb begin
    state_nxt   = state_q;
    div_cnt_nxt = div_cnt_q;
    edges_nxt   = edges_q;
    cpol_nxt    = cpol_q;
    cpha_nxt    = cpha_q;
    lsb_nxt     = lsb_q;
    len_nxt     = len_q;
    div_nxt     = div_q;
    cs_sel_nxt  = cs_sel_q;
    tx_nxt      = tx_q;
    rx_nxt      = rx_q;
    sck_nxt     = sck;
    mosi_nxt    = mosi;
    done_nxt    = 1'b0;
    dout_nxt    = dout;

    unique case (state_q)
      IDLE: begin
        sck_nxt  = cpol_q;
        mosi_nxt = 1'b0;
        if (accept) begin
          state_nxt   = SETUP;
          cpol_nxt    = cfg_cpol;
          cpha_nxt    = cfg_cpha;
          lsb_nxt     = cfg_lsb_first;
          len_nxt     = cfg_len;
          div_nxt     = cfg_div;
          cs_sel_nxt  = cfg_cs_sel;
          div_cnt_nxt = cfg_div;
          edges_nxt   = (EW'(cfg_len) + EW'(1)) << 1;
          rx_nxt      = '0;
          sck_nxt     = cfg_cpol;
          if (!cfg_cpha) begin
            mosi_nxt = head_bit(tx_aligned, cfg_lsb_first);
            tx_nxt   = advance(tx_aligned, cfg_lsb_first);
          end else begin
            tx_nxt   = tx_aligned;
          end
        end
      end

      SETUP, SHIFT: begin
        if (abort) begin
          state_nxt = IDLE;
          sck_nxt   = cpol_q;
          mosi_nxt  = 1'b0;
        end else if (tc) begin
          div_cnt_nxt = div_q;
          edges_nxt   = edges_q - EW'(1);
          sck_nxt     = ~sck;
          if (sample_edge) begin
            rx_nxt = lsb_q ? {miso, rx_q[W-1:1]} : {rx_q[W-2:0], miso};
          end
          if (drive_edge) begin
            mosi_nxt = head_bit(tx_q, lsb_q);
            tx_nxt   = advance(tx_q, lsb_q);
          end
          state_nxt = last_edge ? HOLD : SHIFT;
        end else begin
          div_cnt_nxt = div_cnt_q - DIV_WIDTH'(1);
        end
      end

      HOLD: begin
        if (abort) begin
          state_nxt = IDLE;
          sck_nxt   = cpol_q;
          mosi_nxt  = 1'b0;
        end else if (tc) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
          mosi_nxt  = 1'b0;
          // LSB-first bits were shifted in from the top; right-align them.
          dout_nxt  = lsb_q ? (rx_q >> (~len_q)) : rx_q;
        end else begin
          div_cnt_nxt = div_cnt_q - DIV_WIDTH'(1);
        end
      end

      DONE: begin
        state_nxt = IDLE;
        sck_nxt   = cpol_q;
        mosi_nxt  = 1'b0;
      end

      default: begin
        state_nxt = IDLE;
        sck_nxt   = cpol_q;
        mosi_nxt  = 1'b0;
      end
    endcase

    cs_active_nxt = (state_nxt == SETUP) || (state_nxt == SHIFT) ||
                    (state_nxt == HOLD);
    for (int i = 0; i < CS_NUM; i++) begin
      cs_n_nxt[i] = !(cs_active_nxt && (cs_sel_nxt == CS_SEL_W'(i)));
    end
    start_ready_nxt = (state_nxt == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      div_cnt_q   <= '0;
      edges_q     <= '0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      lsb_q       <= 1'b0;
      len_q       <= '0;
      div_q       <= '0;
      cs_sel_q    <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      sck         <= 1'b0;
      mosi        <= 1'b0;
      done        <= 1'b0;
      dout        <= '0;
      cs_n        <= '1;
      start_ready <= 1'b1;
    end else begin
      state_q     <= state_nxt;
      div_cnt_q   <= div_cnt_nxt;
      edges_q     <= edges_nxt;
      cpol_q      <= cpol_nxt;
      cpha_q      <= cpha_nxt;
      lsb_q       <= lsb_nxt;
      len_q       <= len_nxt;
      div_q       <= div_nxt;
      cs_sel_q    <= cs_sel_nxt;
      tx_q        <= tx_nxt;
      rx_q        <= rx_nxt;
      sck         <= sck_nxt;
      mosi        <= mosi_nxt;
      done        <= done_nxt;
      dout        <= dout_nxt;
      cs_n        <= cs_n_nxt;
      start_ready <= start_ready_nxt;
    end
  end

endmodule
